// File: rtl/cla_response_checker.sv
// Checks an adder's {cout,res} against a+b+cin over a run of NUM_VECTORS
// accepted samples, counting mismatches and capturing the first failing sample.
module cla_response_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned NUM_VECTORS = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] res,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [9:0]       vec_count,
  output logic [9:0]       err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_res,
  output logic             fail_cout
);

  localparam int unsigned CW      = 10;
  localparam int unsigned SW      = WIDTH + 1;
  localparam logic [CW-1:0] NV_M1 = CW'(NUM_VECTORS - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state;
  logic [CW-1:0] acc_cnt;

  // stage 1: accepted sample
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, s1_res;
  logic             s1_cin, s1_cout;

  // stage 2: compare result plus a copy of the sample for first-failure capture
  logic             s2_valid, s2_mis;
  logic [WIDTH-1:0] s2_a, s2_b, s2_res;
  logic             s2_cin, s2_cout;

  logic          accept_c;
  logic          start_ok_c;
  logic [SW-1:0] exp_sum_c;
  logic          mis_c;
  logic [CW-1:0] err_nxt_c;

  always_comb begin
    accept_c   = 1'b0;
    start_ok_c = 1'b0;
    exp_sum_c  = '0;
    mis_c      = 1'b0;
    err_nxt_c  = err_count;
    accept_c   = in_valid && in_ready && (state == RUN);
    start_ok_c = start && ((state == IDLE) || (state == DONE));
    exp_sum_c  = SW'(s1_a) + SW'(s1_b) + SW'(s1_cin);
    mis_c      = s1_valid && (exp_sum_c != {s1_cout, s1_res});
    if (s2_valid && s2_mis && (err_count != CNT_MAX))
      err_nxt_c = err_count + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc_cnt    <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      vec_count  <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_res   <= '0;
      fail_cout  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_cin     <= 1'b0;
      s1_res     <= '0;
      s1_cout    <= 1'b0;
      s2_valid   <= 1'b0;
      s2_mis     <= 1'b0;
      s2_a       <= '0;
      s2_b       <= '0;
      s2_cin     <= 1'b0;
      s2_res     <= '0;
      s2_cout    <= 1'b0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_cin  <= cin;
        s1_res  <= res;
        s1_cout <= cout;
      end

      s2_valid <= s1_valid;
      s2_mis   <= mis_c;
      if (s1_valid) begin
        s2_a    <= s1_a;
        s2_b    <= s1_b;
        s2_cin  <= s1_cin;
        s2_res  <= s1_res;
        s2_cout <= s1_cout;
      end

      if (s2_valid) begin
        vec_count <= vec_count + CW'(1);
        err_count <= err_nxt_c;
        if (s2_mis && !fail_valid) begin
          fail_valid <= 1'b1;
          fail_a     <= s2_a;
          fail_b     <= s2_b;
          fail_cin   <= s2_cin;
          fail_res   <= s2_res;
          fail_cout  <= s2_cout;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start_ok_c) begin
            state      <= RUN;
            acc_cnt    <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
          end
        end
        RUN: begin
          if (accept_c) begin
            acc_cnt <= acc_cnt + CW'(1);
            if (acc_cnt == NV_M1) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // last sample leaves stage 2 on this edge
          if (s2_valid && (vec_count == NV_M1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt_c == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_response_checker.sv
// Directed bench for cla_response_checker: exhaustive 4-bit streams with injected
// faults, restart, mid-run reset and a NUM_VECTORS=4 handshake instance.
module tb_cla_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, in_valid, in_ready;
  logic [3:0] a, b, res;
  logic       cin, cout;
  logic       busy, done, pass, fail_valid;
  logic [9:0] vec_count, err_count;
  logic [3:0] fail_a, fail_b, fail_res;
  logic       fail_cin, fail_cout;

  logic       start4, in_valid4, in_ready4;
  logic [3:0] a4, b4, res4;
  logic       cin4, cout4;
  logic       busy4, done4, pass4, fail_valid4;
  logic [9:0] vec_count4, err_count4;
  logic [3:0] fail_a4, fail_b4, fail_res4;
  logic       fail_cin4, fail_cout4;

  cla_response_checker #(.WIDTH(4), .NUM_VECTORS(512)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .res(res), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin),
    .fail_res(fail_res), .fail_cout(fail_cout)
  );

  cla_response_checker #(.WIDTH(4), .NUM_VECTORS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .res(res4), .cout(cout4),
    .busy(busy4), .done(done4), .pass(pass4), .vec_count(vec_count4), .err_count(err_count4),
    .fail_valid(fail_valid4), .fail_a(fail_a4), .fail_b(fail_b4), .fail_cin(fail_cin4),
    .fail_res(fail_res4), .fail_cout(fail_cout4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // mode 0: good adder; 1: single fault at a=3,b=5; 2: carry fault at a=F,b=1 plus 4 more
  task automatic set_sample(input int idx, input int mode);
    logic [8:0] v;
    logic [4:0] s;
    v   = 9'(idx);
    a   = v[3:0];
    b   = v[7:4];
    cin = v[8];
    s   = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
    if (mode == 1 && v == 9'h053) s = 5'h09;
    if (mode == 2 && v == 9'h01F) s = 5'h00;
    if (mode == 2 && (idx == 100 || idx == 200 || idx == 300 || idx == 400)) s[0] = ~s[0];
    {cout, res} = s;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input int mode, output int cyc, output int drops,
                            output logic dr_ready, output logic dr_busy);
    drops = 0;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 512; i++) begin
      set_sample(i, mode);
      in_valid = 1'b1;
      if (!in_ready) drops++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    dr_ready = in_ready;
    dr_busy  = busy;
    cyc = 512;
    while (!done && cyc < 700) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int   cyc, drops, acc4;
  logic dr_ready, dr_busy;

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; res = '0; cout = 1'b0;
    start4 = 1'b0; in_valid4 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0; res4 = '0; cout4 = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_stable_vec", 32'(vec_count), 32'd0);
    chk("idle_stable_pass", 32'(pass), 32'd0);

    // exhaustive good adder
    run_stream(0, cyc, drops, dr_ready, dr_busy);
    chk("good_ready_drops", 32'(drops), 32'd0);
    chk("good_drain_ready", 32'(dr_ready), 32'd0);
    chk("good_drain_busy", 32'(dr_busy), 32'd1);
    chk("good_cycles", 32'(cyc), 32'd514);
    chk("good_done", 32'(done), 32'd1);
    chk("good_busy", 32'(busy), 32'd0);
    chk("good_vec", 32'(vec_count), 32'd512);
    chk("good_err", 32'(err_count), 32'd0);
    chk("good_pass", 32'(pass), 32'd1);
    chk("good_fail_valid", 32'(fail_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("good_done_held", 32'(done), 32'd1);

    // single sum fault, started from DONE
    run_stream(1, cyc, drops, dr_ready, dr_busy);
    chk("sf_cycles", 32'(cyc), 32'd514);
    chk("sf_vec", 32'(vec_count), 32'd512);
    chk("sf_err", 32'(err_count), 32'd1);
    chk("sf_pass", 32'(pass), 32'd0);
    chk("sf_fail_valid", 32'(fail_valid), 32'd1);
    chk("sf_fail_a", 32'(fail_a), 32'h3);
    chk("sf_fail_b", 32'(fail_b), 32'h5);
    chk("sf_fail_cin", 32'(fail_cin), 32'd0);
    chk("sf_fail_res", 32'(fail_res), 32'h9);
    chk("sf_fail_cout", 32'(fail_cout), 32'd0);

    // carry fault first, then four more mismatches
    run_stream(2, cyc, drops, dr_ready, dr_busy);
    chk("cf_err", 32'(err_count), 32'd5);
    chk("cf_pass", 32'(pass), 32'd0);
    chk("cf_fail_a", 32'(fail_a), 32'hF);
    chk("cf_fail_b", 32'(fail_b), 32'h1);
    chk("cf_fail_cin", 32'(fail_cin), 32'd0);
    chk("cf_fail_res", 32'(fail_res), 32'h0);
    chk("cf_fail_cout", 32'(fail_cout), 32'd0);

    // restart from DONE with err_count=5
    pulse_start();
    chk("rs_vec", 32'(vec_count), 32'd0);
    chk("rs_err", 32'(err_count), 32'd0);
    chk("rs_fail_valid", 32'(fail_valid), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_ready", 32'(in_ready), 32'd1);

    // 100 accepts with a start pulse mid-run (ignored), then asynchronous reset
    for (int i = 0; i < 100; i++) begin
      set_sample(i, 0);
      in_valid = 1'b1;
      start = (i == 50);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("mid_vec", 32'(vec_count), 32'd98);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state_ready", 32'(in_ready), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_pass", 32'(pass), 32'd0);
    chk("ar_vec", 32'(vec_count), 32'd0);
    chk("ar_err", 32'(err_count), 32'd0);
    chk("ar_fail_valid", 32'(fail_valid), 32'd0);
    chk("ar_fail_bus", 32'({fail_a, fail_b, fail_cin, fail_res, fail_cout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_no_done", 32'(done), 32'd0);
    chk("ar_no_busy", 32'(busy), 32'd0);
    pulse_start();
    chk("ar_restart_vec", 32'(vec_count), 32'd0);
    chk("ar_restart_busy", 32'(busy), 32'd1);

    // handshake on the NUM_VECTORS=4 instance; samples after the 4th carry bad sums
    acc4 = 0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic [4:0] s;
      in_valid4 = (k % 2 == 0);
      a4   = 4'(k);
      b4   = 4'(k + 1);
      cin4 = 1'b0;
      s    = {1'b0, a4} + {1'b0, b4};
      if (k >= 8) s[0] = ~s[0];
      {cout4, res4} = s;
      if (k == 8) chk("hs_ready_after4", 32'(in_ready4), 32'd0);
      if (in_valid4 && in_ready4) acc4++;
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    chk("hs_accepts", 32'(acc4), 32'd4);
    chk("hs_done", 32'(done4), 32'd1);
    chk("hs_vec", 32'(vec_count4), 32'd4);
    chk("hs_err", 32'(err_count4), 32'd0);
    chk("hs_pass", 32'(pass4), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_response_checker.md
CLA_RESPONSE_CHECKER -- requirements
Module: cla_response_checker

Interface
REQ-001 Parameter WIDTH, default 4: operand and sum width of the adder under check.
REQ-002 Parameter NUM_VECTORS, default 512: number of accepted samples per run; legal range 1..1023.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a run.
REQ-006 in_valid  input  1  a sample is present on a/b/cin/res/cout.
REQ-007 in_ready  output  1  checker accepts a sample this cycle.
REQ-008 a, b  input  WIDTH each  operands applied to the adder.
REQ-009 cin  input  1  carry-in applied to the adder.
REQ-010 res  input  WIDTH  adder sum output under check.
REQ-011 cout  input  1  adder carry-out under check.
REQ-012 busy  output  1  run in progress.
REQ-013 done  output  1  run complete; held until next start or reset.
REQ-014 pass  output  1  valid only while done=1; 1 = zero mismatches.
REQ-015 vec_count  output  10  samples compared in current run.
REQ-016 err_count  output  10  mismatches in current run; saturates at 1023.
REQ-017 fail_valid  output  1  first-failure capture registers hold data.
REQ-018 fail_a, fail_b, fail_res  output  WIDTH each; fail_cin, fail_cout  output  1 each: first mismatching sample.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-020 IDLE -> RUN on start=1; counters, fail_valid and the pipeline are cleared on that same edge.
REQ-021 in_ready=1 only in RUN and only while accepted-sample count < NUM_VECTORS; a sample is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-022 in_valid without in_ready is ignored; no sample is buffered or lost-counted.
REQ-023 Stage 1: accepted sample registered (latency 1).
REQ-024 Stage 2: expected = a + b + cin at WIDTH+1 bits; mismatch when {cout,res} differs from expected; vec_count increments and err_count increments on mismatch on the edge 2 cycles after acceptance.
REQ-025 First mismatch only: fail_* loaded and fail_valid set on the same edge as err_count first increments; later mismatches do not overwrite.
REQ-026 err_count holds at 1023 when saturated; vec_count keeps counting.
REQ-027 RUN -> DRAIN on the edge accepting sample number NUM_VECTORS; DRAIN -> DONE on the edge vec_count reaches NUM_VECTORS.
REQ-028 busy=1 in RUN and DRAIN; done=1 only in DONE; pass = done and err_count==0.
REQ-029 start in RUN or DRAIN is ignored; start in DONE behaves as in IDLE (REQ-020).
REQ-030 Back-to-back acceptance every cycle is supported (throughput 1 sample/cycle); gaps in in_valid are allowed.

Reset
REQ-031 rst_n low asynchronously forces state IDLE, in_ready=0, busy=0, done=0, pass=0, vec_count=0, err_count=0, fail_valid=0, all fail_* = 0, pipeline valid bits = 0.
REQ-032 rst_n asserted mid-run aborts the run; no done pulse is produced; a new start is required after release.
REQ-033 Outputs are stable after reset release until the first start.

Verification
REQ-034 Exhaustive good adder: start, drive all 512 {cin,b,a} combinations with correct res/cout, in_valid continuous -> done after 514 cycles from first accept, vec_count=512, err_count=0, pass=1, fail_valid=0.
REQ-035 Single fault: same stream, sample a=4'h3, b=4'h5, cin=0 driven with res=4'h9 -> err_count=1, pass=0, fail_a=3, fail_b=5, fail_cin=0, fail_res=9, fail_cout=0.
REQ-036 Carry fault: a=4'hF, b=4'h1, cin=0 with res=0, cout=0, followed by further mismatches -> fail_* hold first fault only (fail_res=0, fail_cout=0), err_count equals injected count.
REQ-037 Handshake: NUM_VECTORS=4, in_valid toggled 1/0 per cycle, extra valid samples after 4th -> in_ready drops after 4th accept, vec_count=4, extra samples not counted.
REQ-038 Reset mid-run: assert rst_n=0 after 100 accepts -> all outputs at REQ-031 values immediately; start after release begins with vec_count=0.
REQ-039 Restart: start while in DONE with prior err_count=5 -> counters and fail_valid clear on that edge, done=0, busy=1.
